// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and drain length for the pipe_ctrl sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED,
        ERROR
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// pipe_perf_cnt: W-bit saturating event counter, built only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing controller: start-up, stalls, flushes, memory waits, halt drain.
// Optional stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic Stall_Req,
    input  logic Branch_Taken,
    input  logic Halt_Req,
    input  logic DMEM_Access,
    input  logic DMEM_Ack,
    output logic DMEM_Req,
    output logic PC_En,
    output logic IF_ID_En,
    output logic ID_EX_En,
    output logic EX_MEM_En,
    output logic MEM_WB_En,
    output logic IF_ID_Flush,
    output logic ID_EX_Bubble,
    output logic Halted,
    output logic Err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
`endif
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    state_e              eff_state;
    logic                acked;
    logic                mem_stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ret_q   <= RUN;
            wait_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        eff_state    = state_q;
        acked        = 1'b0;
        DMEM_Req     = 1'b0;
        PC_En        = 1'b0;
        IF_ID_En     = 1'b0;
        ID_EX_En     = 1'b0;
        EX_MEM_En    = 1'b0;
        MEM_WB_En    = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;

        // An ack in MEM_WAIT replays the suspended state's rules in the same cycle.
        if ((state_q == MEM_WAIT) && DMEM_Ack) begin
            eff_state = ret_q;
            acked     = 1'b1;
            state_d   = ret_q;
        end
        mem_stall = ((eff_state == RUN) || (eff_state == DRAIN)) && DMEM_Access && !DMEM_Ack;

        case (eff_state)
            IDLE: begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
                state_d      = RUN;
            end
            RUN: begin
                DMEM_Req = DMEM_Access || acked;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    ret_d   = RUN;
                    wait_d  = '0;
                end else if (Halt_Req) begin
                    ID_EX_En  = 1'b1;
                    EX_MEM_En = 1'b1;
                    MEM_WB_En = 1'b1;
                    state_d   = DRAIN;
                    drain_d   = '0;
                end else if (Stall_Req) begin
                    ID_EX_En     = 1'b1;
                    EX_MEM_En    = 1'b1;
                    MEM_WB_En    = 1'b1;
                    ID_EX_Bubble = 1'b1;
                end else begin
                    PC_En       = 1'b1;
                    IF_ID_En    = 1'b1;
                    ID_EX_En    = 1'b1;
                    EX_MEM_En   = 1'b1;
                    MEM_WB_En   = 1'b1;
                    IF_ID_Flush = Branch_Taken;
                end
            end
            MEM_WAIT: begin
                // The originating RUN/DRAIN cycle counts as the first unacknowledged cycle.
                DMEM_Req = 1'b1;
                wait_d   = wait_q + 1'b1;
                if (32'(wait_q) + 32'd2 >= MAX_WAIT) begin
                    state_d = ERROR;
                end
            end
            DRAIN: begin
                DMEM_Req = DMEM_Access || acked;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    ret_d   = DRAIN;
                    wait_d  = '0;
                end else begin
                    ID_EX_En     = 1'b1;
                    EX_MEM_En    = 1'b1;
                    MEM_WB_En    = 1'b1;
                    ID_EX_Bubble = 1'b1;
                    drain_d      = drain_q + 1'b1;
                    if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d = HALTED;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign Halted = (state_q == HALTED);
    assign Err    = (state_q == ERROR);

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT) || (state_q == DRAIN)) && !PC_En;
    assign flush_inc = (state_q == RUN) && IF_ID_Flush;

    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (stall_inc),
        .cnt_o (Stall_Cnt)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (flush_inc),
        .cnt_o (Flush_Cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic against a
// cycle-level reference built from unacked-cycle and drain-remaining counts.
module tb_pipe_ctrl;

    localparam int unsigned MAX_WAIT  = 15;
    localparam int          DRAIN_LEN = 3;
`ifdef PIPE_CTRL_PERF_EN
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Stall_Req = 1'b0;
    logic Branch_Taken = 1'b0;
    logic Halt_Req = 1'b0;
    logic DMEM_Access = 1'b0;
    logic DMEM_Ack = 1'b0;
    logic DMEM_Req, PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En;
    logic IF_ID_Flush, ID_EX_Bubble, Halted, Err;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
`endif

    pipe_ctrl #(
        .MAX_WAIT (MAX_WAIT)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Stall_Req    (Stall_Req),
        .Branch_Taken (Branch_Taken),
        .Halt_Req     (Halt_Req),
        .DMEM_Access  (DMEM_Access),
        .DMEM_Ack     (DMEM_Ack),
        .DMEM_Req     (DMEM_Req),
        .PC_En        (PC_En),
        .IF_ID_En     (IF_ID_En),
        .ID_EX_En     (ID_EX_En),
        .EX_MEM_En    (EX_MEM_En),
        .MEM_WB_En    (MEM_WB_En),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Bubble (ID_EX_Bubble),
        .Halted       (Halted),
        .Err          (Err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .Stall_Cnt    (Stall_Cnt),
        .Flush_Cnt    (Flush_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: expressed as progress counters, not controller states.
    bit m_booted, m_waiting, m_halted, m_err;
    int m_unacked, m_drain_left;
    int m_stall_cnt, m_flush_cnt;

    // Vector order: req, pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, halted, err
    localparam logic [9:0] IDLE_VEC = 10'b00_0000_1100;

    function automatic logic [9:0] outs();
        return {DMEM_Req, PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
                IF_ID_Flush, ID_EX_Bubble, Halted, Err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 0; m_waiting = 0; m_halted = 0; m_err = 0;
        m_unacked = 0; m_drain_left = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // Assert RST between edges, confirm outputs immediately, hold over two edges, release.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        Stall_Req = 0; Branch_Taken = 0; Halt_Req = 0; DMEM_Access = 0; DMEM_Ack = 0;
        #1;
        check({tag, "_rst_outs"}, 32'(outs()), 32'(IDLE_VEC));
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_rst_cnt"}, {Stall_Cnt, Flush_Cnt}, 0);
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict outputs, check at the falling edge.
    task automatic cycle(input string tag, input logic st, input logic br, input logic hl,
                         input logic ac, input logic ak);
        logic [9:0] e;
        bit in_run, in_active;
        Stall_Req = st; Branch_Taken = br; Halt_Req = hl; DMEM_Access = ac; DMEM_Ack = ak;
        e = '0;
        in_active = m_booted && !m_err && !m_halted;
        in_run    = in_active && !m_waiting && (m_drain_left == 0);
        if (!m_booted) begin
            e = IDLE_VEC;
            m_booted = 1;
        end else if (m_err) begin
            e[0] = 1'b1;
        end else if (m_halted) begin
            e[1] = 1'b1;
        end else if (m_waiting && !ak) begin
            e[9] = 1'b1;
            m_unacked++;
            if (m_unacked >= int'(MAX_WAIT)) m_err = 1;
        end else if (!m_waiting && ac && !ak) begin
            e[9] = 1'b1;
            m_waiting = 1;
            m_unacked = 1;
        end else begin
            e[9] = m_waiting | ac;
            m_waiting = 0;
            if (m_drain_left > 0) begin
                e[6:4] = 3'b111; e[2] = 1'b1;
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (hl) begin
                e[6:4] = 3'b111;
                m_drain_left = DRAIN_LEN;
            end else if (st) begin
                e[6:4] = 3'b111; e[2] = 1'b1;
            end else begin
                e[8:4] = 5'b11111; e[3] = br;
            end
        end
        @(negedge CLK);
        check(tag, 32'(outs()), 32'(e));
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_stall_cnt"}, 32'(Stall_Cnt), m_stall_cnt);
        check({tag, "_flush_cnt"}, 32'(Flush_Cnt), m_flush_cnt);
        if (in_active && !e[8] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (in_run && e[3] && m_flush_cnt < CNT_MAX) m_flush_cnt++;
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_cycle(input string tag);
        cycle(tag, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        model_reset();
        #2;
        do_reset("init");
        cycle("idle", 0, 0, 0, 0, 0);
        cycle("run_first", 0, 0, 0, 0, 0);

        cycle("stall", 1, 0, 0, 0, 0);
        cycle("stall_branch", 1, 1, 0, 0, 0);
        cycle("branch", 0, 1, 0, 0, 0);
        cycle("run", 0, 0, 0, 0, 0);
        cycle("ack_no_req", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) cycle("mem_wait", 0, 0, 0, 1, 0);
        cycle("mem_ack", 0, 0, 0, 1, 1);
        cycle("mem_after", 0, 1, 0, 0, 0);

        for (int i = 0; i < int'(MAX_WAIT); i++) cycle("timeout_wait", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) rand_cycle("err_sticky");
        do_reset("after_err");
        cycle("idle2", 0, 0, 0, 0, 0);

        cycle("pre_halt", 0, 0, 0, 0, 0);
        cycle("halt", 1, 1, 1, 0, 0);
        for (int i = 0; i < DRAIN_LEN; i++) cycle("drain", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) rand_cycle("halted");
        do_reset("after_halt");
        cycle("idle3", 0, 0, 0, 0, 0);

        cycle("halt_m", 0, 0, 1, 0, 0);
        cycle("drain_m1", 0, 0, 0, 0, 0);
        cycle("drain_mstall", 0, 0, 0, 1, 0);
        cycle("drain_mwait", 0, 0, 0, 1, 0);
        cycle("drain_mack", 0, 0, 0, 1, 1);
        cycle("drain_m3", 0, 0, 0, 0, 0);
        cycle("halted_m", 0, 0, 0, 0, 0);
        do_reset("after_halt_m");
        cycle("idle4", 0, 0, 0, 0, 0);

        cycle("pre_async", 0, 0, 0, 0, 0);
        cycle("async_enter", 0, 0, 0, 1, 0);
        DMEM_Access = 1'b1; DMEM_Ack = 1'b0;
        #2 check("async_in_wait_req", 32'(DMEM_Req), 32'd1);
        do_reset("async");
        cycle("async_idle", 0, 0, 0, 1, 1);
        cycle("async_run", 0, 0, 0, 0, 0);

`ifdef PIPE_CTRL_PERF_EN
        do_reset("perf");
        cycle("perf_idle", 0, 0, 0, 0, 0);
        cycle("perf_run", 0, 0, 0, 0, 0);
        cycle("perf_stall1", 1, 0, 0, 0, 0);
        cycle("perf_stall2", 1, 0, 0, 0, 0);
        cycle("perf_branch", 0, 1, 0, 0, 0);
        cycle("perf_run2", 0, 0, 0, 0, 0);
        check("perf_stall_2", 32'(Stall_Cnt), 32'd2);
        check("perf_flush_1", 32'(Flush_Cnt), 32'd1);
        do_reset("perf_sat");
        cycle("sat_idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("sat_stall", 1, 0, 0, 0, 0);
        cycle("sat_run", 0, 0, 0, 0, 0);
        check("perf_stall_sat", 32'(Stall_Cnt), 32'd3);
`endif

        for (int seg = 0; seg < 25; seg++) begin
            do_reset("rand");
            for (int i = 0; i < 40; i++) rand_cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
